uart_rx: RTL and testbench
==========================

# uart_rx

Simple UART receiver that is the receive-side companion of the system's transmitter. It sits on the same CPU memory bus as a wire-OR'ed peripheral selected by `enable`, and samples an 8N1 serial line. It uses the same baud divider as the transmitter so the two interoperate at 115200 baud. Received bytes land in a single-byte buffer with sticky overrun and framing-error flags readable over the bus.

## Interface
- `BAUD_DIVIDER`, default 694: bit period = BAUD_DIVIDER+1 clocks (identical to transmitter); half period HALF = BAUD_DIVIDER>>1.
- `clk`  input  1  system clock.
- `resetn`  input  1  asynchronous, active-low reset.
- `enable`  input  1  address-decode select for this peripheral.
- `mem_valid`  input  1  bus request.
- `mem_ready`  output  1  bus acknowledge, `enable ? rdy : 0`.
- `mem_instr`  input  1  ignored.
- `mem_wstrb`  input  4  byte write strobes; 0 = read.
- `mem_wdata`  input  32  write data.
- `mem_addr`  input  32  only bit 2 decoded: 0 = DATA, 1 = STATUS.
- `mem_rdata`  output  32  read data, 0 when `enable` low.
- `serialIn`  input  1  asynchronous serial line, idle high.

## Operation
- Input synchronizer: 2 flops, reset to 1; `rxs` = second flop output.
- Timer: 20-bit down-counter. "Expiry" = timer==0 in the current state.
- The FSM has five states.
  - IDLE: when `rxs`==0, load timer=HALF and go to START.
  - START: on expiry, sample `rxs`.
    - Sample 0: timer=BAUD_DIVIDER, bitCount=0, go to DATA.
    - Sample 1: glitch; go to IDLE with no flags changed.
  - DATA: on each expiry, `shifter <= {rxs, shifter[7:1]}` (LSB first), bitCount+1, timer=BAUD_DIVIDER. After the 8th bit, go to STOP.
  - STOP: on expiry, sample `rxs`.
    - Sample 1: deliver the byte, go to IDLE.
    - Sample 0: set `ferr`, discard the byte, go to BREAK.
  - BREAK: wait for `rxs`==1, then go to IDLE.
- Delivery of a byte:
  - If `full`==0, `buffer<=shifter` and `full<=1`.
  - Otherwise set `ovr`; `buffer` is kept and the new byte is dropped.
- Bus registers:
  - DATA read: `{24'b0, buffer}`; clears `full`.
  - DATA write: acknowledged, no effect.
  - STATUS read: `{29'b0, ferr, ovr, full}`; no side effects.
  - STATUS write with `mem_wstrb[0]`: `mem_wdata[1]`=1 clears `ovr`, `mem_wdata[2]`=1 clears `ferr` (write-1-to-clear). `full` is unaffected.
- Reading DATA while empty returns the stale buffer and leaves `full` at 0.

## Timing
- Reset values:
  - `rdy`=0, so `mem_ready`=0.
  - `mem_rdata`=0 while `enable` is low; a STATUS read after reset returns 0.
  - `buffer`=0, `full`=`ovr`=`ferr`=0.
  - FSM in IDLE, timer=0, synchronizer=1.
- Reset asserted mid-frame aborts the frame immediately; the partial byte is lost.
- Handshake:
  - `rdy <= mem_valid & enable & !rdy`, giving a one-cycle pulse one clock after request.
  - Reads and write side effects take effect at the clock edge ending the cycle where `rdy`=1 and `mem_valid & enable` are both high.
  - Read data is valid combinationally during that cycle.
  - If the master holds `mem_valid`, `rdy` re-pulses every other cycle; each pulse is a new access.
- Sample points, with the synchronizer falling edge seen at cycle t0:
  - Start bit sampled at t0+HALF+1.
  - Data bit k sampled at t0+HALF+1+(k+1)(BAUD_DIVIDER+1).
  - Stop bit sampled one period after the last data bit.
  - `full` rises the cycle after the stop sample edge.
- Input-to-detection latency is 2–3 clocks.
- Simultaneous events:
  - DATA read-clear on the same edge as a delivery with `full`=1: the read returns the old byte, `buffer` takes the new byte, `full` stays 1, `ovr` unchanged.
  - STATUS clear on the same edge as a new `ovr`/`ferr` event: the set wins.
  - Next start detection is possible immediately after STOP, so back-to-back transmitter frames (2 stop bits) and 1-stop-bit frames both work.

## Test plan
- Reset/idle, BAUD_DIVIDER=15. Pulse `resetn` low.
  - Required: `mem_ready`=0, `mem_rdata`=0 with `enable`=0.
  - Required: STATUS read = 0x0, with `mem_ready` high exactly 1 cycle after `mem_valid`.
- Single byte: drive 0xA5 8N1 at a 16-clock period.
  - Required: STATUS = 0x1, then DATA = 0x000000A5, then STATUS = 0x0.
- Overrun: send 0x11 then 0x22 without reading.
  - Required: STATUS = 0x3 and DATA = 0x11.
  - Then write STATUS with wdata=0x2 and wstrb=0x1 -> STATUS = 0x0.
- Framing error: send 0x55 with stop bit 0, then hold the line low 40 clocks, then high, then send 0x3C.
  - Required: `ferr` set and no byte delivered for the first frame.
  - Required: after the line returns high, 0x3C is received; STATUS = 0x5 before clearing.
- Glitch and reset:
  - `serialIn` low for 4 clocks (less than HALF=7) -> no delivery, FSM back to IDLE.
  - Assert `resetn` mid-frame -> all flags 0, and the next full frame is received correctly.
- Loopback: connect the transmitter's `serialOut` to `serialIn` with equal BAUD_DIVIDER, transmit 0x00, 0xFF, 0x80, 0x01, reading each byte as it arrives.
  - Required: bytes received in order, bit-exact, with `ovr`=`ferr`=0.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver on the CPU memory bus: a single-byte receive buffer plus sticky
// overrun and framing-error flags, with the same bit timing as the transmitter.
module uart_rx #(
  parameter int BAUD_DIVIDER = 694
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic        serialIn
);

  localparam logic [19:0] BAUD = 20'(BAUD_DIVIDER);
  localparam logic [19:0] HALF = 20'(BAUD_DIVIDER >> 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] timer_q, timer_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shifter_q, shifter_d;
  logic [1:0]  sync_q;
  logic        rxs;
  logic        expired;
  logic        deliver;
  logic        ferr_set;

  logic        rdy;
  logic [7:0]  buffer;
  logic        full;
  logic        ovr;
  logic        ferr;
  logic        access;
  logic        is_write;
  logic        sel_status;
  logic        data_rd;
  logic        stat_wr;
  logic        full_eff;
  logic [31:0] status_word;
  logic [31:0] reg_rdata;
  logic        unused_bus;

  assign unused_bus = ^{mem_instr, mem_wdata[31:3], mem_wdata[0],
                        mem_addr[31:3], mem_addr[1:0]};

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], serialIn};
    end
  end

  assign rxs = sync_q[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shifter_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shifter_q <= shifter_d;
    end
  end

  assign expired = (timer_q == 20'd0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shifter_d = shifter_q;
    deliver   = 1'b0;
    ferr_set  = 1'b0;
    if (!expired) begin
      timer_d = timer_q - 20'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          timer_d = HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        // A start bit that is high again at mid-bit is treated as a glitch.
        if (expired) begin
          if (!rxs) begin
            timer_d   = BAUD;
            bit_cnt_d = 3'd0;
            state_d   = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (expired) begin
          shifter_d = {rxs, shifter_q[7:1]};
          timer_d   = BAUD;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (expired) begin
          if (rxs) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake: rdy pulses for one cycle, one clock after mem_valid & enable; the
  // access (read data returned, side effects applied) happens in the cycle where
  // rdy, mem_valid and enable are all high, committing at the edge that ends it.
  assign access     = rdy & mem_valid & enable;
  assign is_write   = |mem_wstrb;
  assign sel_status = mem_addr[2];
  assign data_rd    = access & ~is_write & ~sel_status;
  assign stat_wr    = access & sel_status & mem_wstrb[0];

  // A DATA read on the same edge as a delivery frees the buffer for the new byte.
  assign full_eff = full & ~data_rd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdy    <= 1'b0;
      buffer <= '0;
      full   <= 1'b0;
      ovr    <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      rdy <= mem_valid & enable & ~rdy;
      if (deliver && !full_eff) begin
        buffer <= shifter_q;
      end
      if (deliver && !full_eff) begin
        full <= 1'b1;
      end else if (data_rd) begin
        full <= 1'b0;
      end
      if (deliver && full_eff) begin
        ovr <= 1'b1;
      end else if (stat_wr && mem_wdata[1]) begin
        ovr <= 1'b0;
      end
      if (ferr_set) begin
        ferr <= 1'b1;
      end else if (stat_wr && mem_wdata[2]) begin
        ferr <= 1'b0;
      end
    end
  end

  assign status_word = {29'b0, ferr, ovr, full};
  assign reg_rdata   = sel_status ? status_word : {24'b0, buffer};
  assign mem_rdata   = enable ? reg_rdata : 32'b0;
  assign mem_ready   = enable ? rdy : 1'b0;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-level serial driver, bus tasks, a register-level
// model of buffer/flags checked on every bus access, and literal expectations.
module tb_uart_rx;

  localparam int BAUD_DIVIDER = 15;
  localparam int BIT_CLKS     = BAUD_DIVIDER + 1;
  localparam logic [31:0] ADDR_DATA   = 32'h0;
  localparam logic [31:0] ADDR_STATUS = 32'h4;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        serialIn;

  int n_cmp = 0;
  int n_err = 0;

  // Register-level model: what the bus must show, derived from whole frames.
  logic [7:0] m_buf;
  logic       m_full;
  logic       m_ovr;
  logic       m_ferr;
  logic [7:0] exp_q[$];

  logic [31:0] d;
  logic [7:0]  exp_b;
  logic [7:0]  loop_bytes[4] = '{8'h00, 8'hFF, 8'h80, 8'h01};

  uart_rx #(.BAUD_DIVIDER(BAUD_DIVIDER)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_instr (mem_instr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .serialIn  (serialIn)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_buf  = 8'h00;
    m_full = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) begin
      m_ferr = 1'b1;
    end else if (!m_full) begin
      m_buf  = b;
      m_full = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endfunction

  // Scoreboard compare process: every cycle, mid low phase.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (!enable) begin
        check("idle_rdata", mem_rdata, 32'h0);
        check("idle_ready", 32'(mem_ready), 32'h0);
      end else if (mem_ready && mem_valid) begin
        exp = mem_addr[2] ? {29'b0, m_ferr, m_ovr, m_full} : {24'b0, m_buf};
        check("model_rdata", mem_rdata, exp);
        if (mem_addr[2] && mem_wstrb[0]) begin
          if (mem_wdata[1]) m_ovr = 1'b0;
          if (mem_wdata[2]) m_ferr = 1'b0;
        end else if (!mem_addr[2] && mem_wstrb == 4'h0) begin
          m_full = 1'b0;
        end
      end
    end
  end

  // Driver tasks
  task automatic bus(input logic [31:0] addr, input logic [3:0] wstrb,
                     input logic [31:0] wdata, output logic [31:0] rdata);
    @(negedge clk);
    enable    = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wstrb = wstrb;
    mem_wdata = wdata;
    #1 check("ready_early", 32'(mem_ready), 32'h0);
    @(negedge clk);
    #1 check("ready_lat", 32'(mem_ready), 32'h1);
    rdata = mem_rdata;
    @(negedge clk);
    #1 check("ready_pulse", 32'(mem_ready), 32'h0);
    mem_valid = 1'b0;
    enable    = 1'b0;
    mem_addr  = 32'h0;
    mem_wstrb = 4'h0;
    mem_wdata = 32'h0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] rdata);
    bus(addr, 4'h0, 32'h0, rdata);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] unused_rd;
    bus(addr, 4'h1, wdata, unused_rd);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int n_stop);
    @(negedge clk);
    serialIn = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serialIn = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    serialIn = stop_val;
    repeat (BIT_CLKS * n_stop) @(negedge clk);
    model_frame(b, stop_val);
  endtask

  task automatic wait_full();
    logic [31:0] s;
    s = 32'h0;
    for (int i = 0; i < 50; i++) begin
      rd(ADDR_STATUS, s);
      if (s[0]) break;
    end
    check("wait_full", 32'(s[0]), 32'h1);
  endtask

  initial begin
    resetn    = 1'b0;
    enable    = 1'b0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_wstrb = 4'h0;
    mem_wdata = 32'h0;
    mem_addr  = 32'h0;
    serialIn  = 1'b1;
    model_reset();

    // Reset / idle
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(mem_ready), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    rd(ADDR_STATUS, d);
    check("rst_status", d, 32'h0);

    // Single byte
    send_frame(8'hA5, 1'b1, 1);
    repeat (4) @(negedge clk);
    rd(ADDR_STATUS, d); check("a5_status_full", d, 32'h1);
    rd(ADDR_DATA, d);   check("a5_data", d, 32'h0000_00A5);
    rd(ADDR_STATUS, d); check("a5_status_empty", d, 32'h0);

    // Overrun with back-to-back 1-stop frames
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1);
    repeat (4) @(negedge clk);
    rd(ADDR_STATUS, d); check("ovr_status", d, 32'h3);
    wr(ADDR_DATA, 32'h0000_0099);
    rd(ADDR_STATUS, d); check("data_write_noeffect", d, 32'h3);
    rd(ADDR_DATA, d);   check("ovr_data", d, 32'h11);
    rd(ADDR_STATUS, d); check("ovr_after_read", d, 32'h2);
    wr(ADDR_STATUS, 32'h2);
    rd(ADDR_STATUS, d); check("ovr_cleared", d, 32'h0);

    // Framing error, break, recovery
    send_frame(8'h55, 1'b0, 1);
    repeat (40) @(negedge clk);
    serialIn = 1'b1;
    repeat (4) @(negedge clk);
    rd(ADDR_STATUS, d); check("ferr_no_byte", d, 32'h4);
    send_frame(8'h3C, 1'b1, 1);
    repeat (4) @(negedge clk);
    rd(ADDR_STATUS, d); check("ferr_then_byte", d, 32'h5);
    rd(ADDR_DATA, d);   check("ferr_data", d, 32'h3C);
    wr(ADDR_STATUS, 32'h4);
    rd(ADDR_STATUS, d); check("ferr_cleared", d, 32'h0);

    // Glitch shorter than half a bit
    @(negedge clk);
    serialIn = 1'b0;
    repeat (4) @(negedge clk);
    serialIn = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    rd(ADDR_STATUS, d); check("glitch_status", d, 32'h0);
    send_frame(8'h6B, 1'b1, 1);
    repeat (4) @(negedge clk);
    rd(ADDR_DATA, d);   check("glitch_next_data", d, 32'h6B);

    // Reset mid-frame with flags set
    send_frame(8'h12, 1'b1, 1);
    send_frame(8'h34, 1'b1, 1);
    @(negedge clk);
    serialIn = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      serialIn = i[0];
      repeat (BIT_CLKS) @(negedge clk);
    end
    resetn   = 1'b0;
    serialIn = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    rd(ADDR_STATUS, d); check("midrst_status", d, 32'h0);
    rd(ADDR_DATA, d);   check("midrst_buffer", d, 32'h0);
    send_frame(8'hC3, 1'b1, 1);
    repeat (4) @(negedge clk);
    rd(ADDR_DATA, d);   check("midrst_next_data", d, 32'hC3);

    // Loopback-style transmitter frames with two stop bits
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(loop_bytes[k]);
      send_frame(loop_bytes[k], 1'b1, 2);
      wait_full();
      rd(ADDR_DATA, d);
      exp_b = exp_q.pop_front();
      check("loop_data", d, {24'b0, exp_b});
    end
    rd(ADDR_STATUS, d); check("loop_status", d, 32'h0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
